// File: rtl/ltc1197_spi_master.sv
// SPI master for the LTC1197 10-bit ADC. It generates cs_n and sclk, shifts in
// the null bit and the data word, and offers each sample on a valid/ready handshake.
module ltc1197_spi_master #(
    parameter int CLK_DIV      = 4,
    parameter int CS_HIGH_CLKS = 8,
    parameter int DATA_W       = 10
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              adc_dout,
    output logic              cs_n,
    output logic              sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              null_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HIGH_CLKS - 1);
    localparam logic [3:0] BIT_LAST  = 4'(DATA_W + 2);

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        hold_q, hold_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              null_err_q, null_err_d;
    logic              overrun_q, overrun_d;
    logic              tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            hold_q     <= '0;
            sclk_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            shreg_q    <= '0;
            err_q      <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            null_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            hold_q     <= hold_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            shreg_q    <= shreg_d;
            err_q      <= err_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            null_err_q <= null_err_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        hold_d     = hold_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        shreg_d    = shreg_q;
        err_d      = err_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        null_err_d = 1'b0;
        overrun_d  = 1'b0;

        // A consume is applied first so a capture on the same edge wins.
        if (valid_q && sample_ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                div_d  = '0;
                sclk_d = 1'b1;
                cs_n_d = 1'b1;
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    bit_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                end
            end
            SHIFT: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) begin
                    if (!sclk_q) begin
                        // Rising sclk: bit 0 is the acquisition bit, bit 1 the null bit.
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 4'd1;
                        if (bit_q == 4'd1 && adc_dout) err_d = 1'b1;
                        if (bit_q >= 4'd2) shreg_d = {shreg_q[DATA_W-2:0], adc_dout};
                    end else if (bit_q == BIT_LAST) begin
                        state_d    = HOLD;
                        cs_n_d     = 1'b1;
                        hold_d     = '0;
                        sample_d   = shreg_q;
                        valid_d    = 1'b1;
                        null_err_d = err_q;
                        overrun_d  = valid_q && !sample_ready;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign null_err     = null_err_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ltc1197_spi_master.sv
// Randomized bench for ltc1197_spi_master with a behavioural LTC1197 model and
// a frame-level reference of timing, captured word and handshake flags.
module tb_ltc1197_spi_master;

    localparam int CLK_DIV = 4;
    localparam int CS_HIGH = 8;
    localparam int DATA_W  = 10;
    localparam int FRAME_LOW = 25 * CLK_DIV;

    logic              clk;
    logic              reset_b;
    logic              start;
    logic              adc_dout;
    logic              cs_n;
    logic              sclk;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              null_err;
    logic              overrun;
    logic              busy;

    int n_chk;
    int n_pass;

    ltc1197_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_HIGH_CLKS(CS_HIGH), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .adc_dout(adc_dout),
        .cs_n(cs_n), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .null_err(null_err), .overrun(overrun),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ADC model: each queue entry is {null_bit, word}; bit k goes out 68 ns after sclk fall k.
    logic [10:0] adc_q[$];
    logic [10:0] cur;
    int          fidx;
    logic        adc_b;

    initial adc_dout = 1'b0;

    always @(negedge cs_n) begin
        if (adc_q.size() > 0) cur = adc_q.pop_front();
        else cur = 11'($urandom);
        fidx = 0;
    end

    always @(negedge sclk) begin
        if (cs_n == 1'b0) begin
            fidx = fidx + 1;
            if (fidx == 1) adc_b = 1'($urandom);
            else if (fidx == 2) adc_b = cur[10];
            else if (fidx <= 12) adc_b = cur[12 - fidx];
            else adc_b = 1'b0;
            #68;
            adc_dout = adc_b;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Waits for cs_n low, counts clocks low and sclk falls, then samples outputs
    // right after the capture edge and once more a clock later.
    task automatic run_frame(output int low, output int falls, output logic [9:0] smp,
                             output logic v, output logic ne, output logic ov,
                             output logic v2, output logic ne2, output logic ov2);
        int   t = 0;
        logic prev;
        while (cs_n !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        low = 0;
        falls = 0;
        prev = sclk;
        while (cs_n === 1'b0 && low < 3000) begin
            low++;
            if (prev === 1'b1 && sclk === 1'b0) falls++;
            prev = sclk;
            @(negedge clk);
        end
        smp = sample;
        v   = sample_valid;
        ne  = null_err;
        ov  = overrun;
        @(negedge clk);
        v2  = sample_valid;
        ne2 = null_err;
        ov2 = overrun;
    endtask

    int         low, falls, gap;
    logic [9:0] smp, w;
    logic       v, ne, ov, v2, ne2, ov2, nb, r;
    logic       pend;

    initial begin
        reset_b = 1'b0;
        start = 1'b0;
        sample_ready = 1'b0;
        pend = 1'b0;
        n_chk = 0;
        n_pass = 0;

        repeat (3) @(negedge clk);
        check_val("rst_cs_n", 32'(cs_n), 32'd1);
        check_val("rst_sclk", 32'(sclk), 32'd1);
        check_val("rst_sample", 32'(sample), 32'd0);
        check_val("rst_valid", 32'(sample_valid), 32'd0);
        check_val("rst_null_err", 32'(null_err), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset_b = 1'b1;
        @(negedge clk);

        // Single frame, start pulsed one clock.
        adc_q.push_back({1'b0, 10'b1010101010});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("t1_busy", 32'(busy), 32'd1);
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t1_low_clks", 32'(low), 32'(FRAME_LOW));
        check_val("t1_sclk_falls", 32'(falls), 32'd12);
        check_val("t1_sample", 32'(smp), 32'h2AA);
        check_val("t1_valid", 32'(v), 32'd1);
        check_val("t1_null_err", 32'(ne), 32'd0);
        check_val("t1_overrun", 32'(ov), 32'd0);
        check_val("t1_valid_held", 32'(v2), 32'd1);
        sample_ready = 1'b1;
        @(negedge clk);
        check_val("t1_consume", 32'(sample_valid), 32'd0);
        check_val("t1_sample_kept", 32'(sample), 32'h2AA);
        pend = 1'b0;
        wait_idle();

        // Back-to-back frames with start held and the consumer always ready.
        adc_q.push_back({1'b0, 10'h3FF});
        adc_q.push_back({1'b0, 10'h001});
        start = 1'b1;
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t2a_low_clks", 32'(low), 32'(FRAME_LOW));
        check_val("t2a_sample", 32'(smp), 32'h3FF);
        check_val("t2a_overrun", 32'(ov), 32'd0);
        gap = 1;
        while (cs_n === 1'b1 && gap < 3000) begin
            gap++;
            @(negedge clk);
        end
        check_val("t2_cs_high_gap", 32'(gap), 32'(CS_HIGH + 1));
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        start = 1'b0;
        check_val("t2b_low_clks", 32'(low), 32'(FRAME_LOW));
        check_val("t2b_sample", 32'(smp), 32'h001);
        check_val("t2b_valid", 32'(v), 32'd1);
        check_val("t2b_overrun", 32'(ov), 32'd0);
        pend = 1'b0;
        wait_idle();

        // Randomized frames: random word, null bit and consumer readiness.
        for (int i = 0; i < 6; i++) begin
            w  = 10'($urandom_range(0, 1023));
            nb = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            sample_ready = r;
            adc_q.push_back({nb, w});
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
            check_val("rnd_low_clks", 32'(low), 32'(FRAME_LOW));
            check_val("rnd_sample", 32'(smp), 32'(w));
            check_val("rnd_valid", 32'(v), 32'd1);
            check_val("rnd_null_err", 32'(ne), 32'(nb));
            check_val("rnd_null_err_end", 32'(ne2), 32'd0);
            check_val("rnd_overrun", 32'(ov), 32'(pend && !r));
            check_val("rnd_overrun_end", 32'(ov2), 32'd0);
            check_val("rnd_valid_next", 32'(v2), 32'(!r));
            pend = !r;
            wait_idle();
        end

        // Overrun: two frames with nobody consuming.
        sample_ready = 1'b1;
        @(negedge clk);
        check_val("t3_clear", 32'(sample_valid), 32'd0);
        sample_ready = 1'b0;
        adc_q.push_back({1'b0, 10'h155});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t3a_sample", 32'(smp), 32'h155);
        check_val("t3a_overrun", 32'(ov), 32'd0);
        wait_idle();
        adc_q.push_back({1'b0, 10'h0F0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t3b_sample", 32'(smp), 32'h0F0);
        check_val("t3b_overrun", 32'(ov), 32'd1);
        check_val("t3b_overrun_end", 32'(ov2), 32'd0);
        check_val("t3b_valid", 32'(v2), 32'd1);
        wait_idle();

        // Null bit set; previous word still pending.
        adc_q.push_back({1'b1, 10'h200});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t4_sample", 32'(smp), 32'h200);
        check_val("t4_null_err", 32'(ne), 32'd1);
        check_val("t4_null_err_end", 32'(ne2), 32'd0);
        check_val("t4_overrun", 32'(ov), 32'd1);
        wait_idle();

        // Asynchronous reset in the middle of SHIFT.
        adc_q.push_back({1'b0, 10'h0AB});
        start = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        check_val("t5_cs_low_before", 32'(cs_n), 32'd0);
        reset_b = 1'b0;
        #1;
        check_val("t5_cs_n", 32'(cs_n), 32'd1);
        check_val("t5_sclk", 32'(sclk), 32'd1);
        check_val("t5_valid", 32'(sample_valid), 32'd0);
        check_val("t5_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check_val("t5_no_restart", 32'(cs_n), 32'd1);
        adc_q.push_back({1'b0, 10'h2C3});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(low, falls, smp, v, ne, ov, v2, ne2, ov2);
        check_val("t5_low_clks", 32'(low), 32'(FRAME_LOW));
        check_val("t5_sclk_falls", 32'(falls), 32'd12);
        check_val("t5_sample", 32'(smp), 32'h2C3);
        wait_idle();

        // Consume exactly on the capture edge of the next frame.
        w = 10'($urandom_range(0, 1023));
        adc_q.push_back({1'b0, w});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FRAME_LOW - 1) @(negedge clk);
        check_val("t6_cs_low_last", 32'(cs_n), 32'd0);
        check_val("t6_valid_pending", 32'(sample_valid), 32'd1);
        check_val("t6_sample_stable", 32'(sample), 32'h2C3);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check_val("t6_cs_high", 32'(cs_n), 32'd1);
        check_val("t6_sample", 32'(sample), 32'(w));
        check_val("t6_valid", 32'(sample_valid), 32'd1);
        check_val("t6_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check_val("t6_valid_next", 32'(sample_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ltc1197_spi_master.md
Name: ltc1197_spi_master

Overview:
- Synthesizable FPGA-side SPI master for the LTC1197 10-bit ADC. It is the receiving end of the link the ADC emulator drives.
- Generates cs_n and sclk from the system clock and captures the null bit plus 10 data bits, MSB first.
- Presents each sample on a valid/ready handshake to the downstream acoustics datapath.
- Replaces the separate SIPO/SIPO_controller/counter trio with one self-timed block.

Parameters:
- CLK_DIV, 4, system clocks per sclk half-period (legal range 2..255)
- CS_HIGH_CLKS, 8, minimum system clocks cs_n stays high between frames (legal range 1..255)
- DATA_W, 10, ADC data bits per frame

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous active-low reset
- start  input  1  level request; a frame begins when start=1 is sampled in IDLE
- adc_dout  input  1  serial data from ADC; ADC changes it after the sclk falling edge
- cs_n  output  1  ADC chip select, active low
- sclk  output  1  SPI clock; idles high
- sample  output  DATA_W  last captured word, MSB = first data bit received
- sample_valid  output  1  sample holds an unconsumed word
- sample_ready  input  1  downstream accepts sample when valid&ready
- null_err  output  1  one-clock pulse: null bit read as 1 in the frame just completed
- overrun  output  1  one-clock pulse: new word overwrote an unconsumed word
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low, one clock domain. Reset values: cs_n=1, sclk=1, sample=0, sample_valid=0, null_err=0, overrun=0, busy=0, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately. The next frame starts only after reset_b=1 and start=1.
- Timing reference: the clk edge that samples start=1 in IDLE is edge 0.
- State machine:
  - IDLE: cs_n=1, sclk=1. On start=1 go to SETUP, cs_n←0 at edge 0.
  - SETUP: hold cs_n=0, sclk=1 for CLK_DIV clocks, then go to SHIFT.
  - SHIFT: sclk toggles every CLK_DIV clocks, first transition high→low, at edge CLK_DIV.
    - adc_dout is registered on the clk edge that drives sclk 0→1. The n-th rising edge is at edge (2n)·CLK_DIV.
    - Rising edge 1: sample/acquisition bit, discarded.
    - Rising edge 2: null bit. If it reads 1, set an internal error flag.
    - Rising edges 3..DATA_W+2: data bits B9..B0, shifted in MSB first.
    - After rising edge DATA_W+2, sclk stays high for CLK_DIV more clocks, then go to HOLD.
  - HOLD:
    - Entry edge (edge 25·CLK_DIV for defaults): cs_n←1 and sample←shift register.
    - Same edge: sample_valid←1; null_err pulses if the error flag is set; overrun pulses if sample_valid was 1 and not being consumed on that edge.
    - Stay in HOLD CS_HIGH_CLKS clocks, then go to IDLE. start held high therefore gives back-to-back frames with cs_n high exactly CS_HIGH_CLKS+1 clocks.
- Handshake:
  - sample_valid falls on the edge after valid&ready.
  - A capture on the same edge as a consume leaves sample_valid=1 with the new word, and overrun stays 0.
  - sample is stable while sample_valid=1, except when overwritten at capture.
- start is ignored outside IDLE. There is no queuing.
- Counters:
  - Divider: 8-bit, wraps to 0 at CLK_DIV-1.
  - Bit counter: 4-bit, counts rising edges 1..DATA_W+2, cleared on entry to SETUP.
  - Hold counter: 8-bit.
- Frame length for defaults: 12 sclk periods, 25·CLK_DIV = 100 clocks with cs_n low.

Test Plan:
- Reset at time 0, release after 3 clocks, start pulsed 1 clock. ADC model (68 ns data delay after sclk fall, null bit 0) sends 10'b1010101010. Required: cs_n low 100 clocks, 12 sclk falling edges, sample=10'h2AA, sample_valid=1 at edge 100, null_err=0.
- start held high, sample_ready=1, words 10'h3FF then 10'h001. Required: two frames, cs_n high 9 clocks between them, sample=10'h3FF then 10'h001, overrun=0.
- sample_ready=0, two frames with words 10'h155 then 10'h0F0. Required: overrun pulses 1 clock at the second capture, sample=10'h0F0, sample_valid stays 1.
- ADC model drives null bit=1 with data 10'h200. Required: null_err 1-clock pulse at capture, sample=10'h200.
- Assert reset_b=0 at edge 40 mid-SHIFT. Required: cs_n=1, sclk=1, sample_valid=0 asynchronously. Restart with start=1 gives a full 100-clock frame.
- sample_ready=1 asserted exactly on the capture edge of the next frame (previous word pending). Required: no overrun, sample_valid remains 1 with the new word.
